stall_pipe_n: RTL and testbench
===============================

# stall_pipe_n

Parametrised successor of the two-lane stall pipeline. It accepts operand triples (a, b, c) through a valid/ready handshake and carries them down two independently ordered adder lanes of configurable depth. Lane 1 computes (a+b)+c and lane 2 computes (a+c)+b. Per-stage bubble collapsing, a global stall, a synchronous flush and a sticky lane-mismatch flag are added. The block serves as an equivalence benchmark for formal flows and as a reusable elastic pipeline in the datapath.

## Interface
- W, 16: operand and result width.
- DEPTH, 2: number of register stages, legal range 2..8. DEPTH=2 reproduces the original two-cycle pipeline.
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  1  global freeze: no stage loads, no transfer on either side.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  upstream triple valid.
- in_ready  output  1  block can accept a triple this cycle (combinational).
- a, b, c  input  W each  operands.
- out_valid  output  1  d1/d2 hold a result.
- out_ready  input  1  downstream accepts the result.
- d1  output  W  lane-1 result, (a+b)+c mod 2^W.
- d2  output  W  lane-2 result, (a+c)+b mod 2^W.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.
- mismatch  output  1  sticky: a result was delivered with d1 != d2.

## Operation
- Stage registers S1..S_DEPTH, each with a valid bit v[k].
- S1 payload: p1=a+b, q1=c, p2=a+c, q2=b.
- S2..S_(DEPTH-1) copy the payload unchanged.
- S_DEPTH payload: d1=p1+q1, d2=p2+q2 computed from S_(DEPTH-1).
- All sums are truncated to W bits and carries are discarded.
- Output transfer: fire_out = out_valid & out_ready & !stall.
- Advance terms:
  - adv[DEPTH] = !stall & (!v[DEPTH] | out_ready).
  - adv[k] = !stall & (!v[k] | adv[k+1]) for k < DEPTH.
- Stage k loads from stage k-1 (S1 loads from the inputs) when adv[k]. Its new valid bit is v[k-1] (for S1, in_valid & in_ready).
- A stage whose v=0 may load while downstream is blocked. This collapses bubbles.
- in_ready = adv[1] & !flush.
- Data registers update only on a load that brings a valid entry. The payload of an invalid stage is don't-care, and d1/d2 retain their last value while out_valid=0.
- out_valid = v[DEPTH].
- occupancy is the popcount of v[1..DEPTH], registered and consistent with v every cycle.
- mismatch sets on fire_out when d1 != d2. It clears only on reset.
- Flush:
  - All v[k] clear on the next edge, and occupancy becomes 0.
  - No input is accepted in the flush cycle.
  - An output with out_ready=1 in the flush cycle still transfers (fire_out counts).
  - Flush overrides stall for the valid bits.
- Reset: all valids, all payload registers, d1, d2, occupancy and mismatch go to 0 immediately. A reset mid-operation discards all entries.

## Timing
- Latency: a triple accepted at edge t has out_valid=1 after edge t+DEPTH-1. It is visible in cycle t+DEPTH-1 when no backpressure and no stall occur. DEPTH=2 gives one idle stage between input and output, as in the original block.
- Throughput: 1 triple per cycle while out_ready=1 and stall=0.
- Backpressure: with out_ready=0, the pipeline fills and in_ready drops after DEPTH accepted triples, with no loss and no duplication.
- Simultaneous fire_out and input acceptance with a full pipe is allowed, and occupancy stays at DEPTH.
- stall=1 forces in_ready=0 and holds all registers, outputs and occupancy. out_valid stays asserted, but no output transfer happens.

## Test plan
- DEPTH=2, W=16, out_ready=1: push a=1, b=2, c=3 followed by 0xFFFF, 1, 1.
  - The results are d1=d2=6, then d1=d2=1 (wrap).
  - out_valid rises exactly one cycle after each acceptance, and mismatch stays 0.
- DEPTH=4: hold out_ready=0 and push 5 triples.
  - Exactly 4 are accepted, then in_ready=0 and occupancy=4.
  - Release out_ready. The outputs come out in order with no gaps, then the 5th triple.
- Stream at full rate and assert stall for 3 cycles mid-stream.
  - All registers, occupancy and out_valid are frozen, and in_ready=0.
  - After release, the sequence resumes with no loss or duplication.
- Insert bubbles (in_valid toggling) with out_ready=0, then out_ready=1.
  - Bubbles collapse, so occupancy equals the count of accepted triples.
- Assert flush with occupancy=3 and out_ready=1.
  - The head result transfers, and occupancy=0 on the next edge.
  - No input is taken in that cycle.
- Drop rst_n asynchronously with a full pipe.
  - All outputs go to 0 immediately, with out_valid=0 and mismatch=0.
  - After release, the first accepted triple emerges after DEPTH-1 cycles.

Source files
------------

// File: rtl/stall_pipe_n.sv
`default_nettype none
// ============================================================================
// Module : stall_pipe_n
// Two-lane elastic adder pipeline with stall, flush and sticky mismatch flag.
// Rev    : 1.0
// ============================================================================
module stall_pipe_n #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  logic [W-1:0]               c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               d1,
  output logic [W-1:0]               d2,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       mismatch
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int NP = DEPTH - 1;

  logic [DEPTH:1] v_q, v_d, adv;
  logic [W-1:0]   p1_q [1:NP];
  logic [W-1:0]   q1_q [1:NP];
  logic [W-1:0]   p2_q [1:NP];
  logic [W-1:0]   q2_q [1:NP];
  logic [W-1:0]   d1_q, d2_q;
  logic [OW-1:0]  occ_q, occ_d;
  logic           mism_q;
  logic           full;
  logic           fire_out;

  // adv[k] is blocked only when every stage from k to the output is full
  // and the output is not draining, so the chain is evaluated in closed form.
  always_comb begin
    full = 1'b1;
    adv  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      full   = full & v_q[k];
      adv[k] = !stall && (out_ready || !full);
    end
  end

  assign in_ready = adv[1] & ~flush;
  assign fire_out = v_q[DEPTH] & out_ready & ~stall;

  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[1]) v_d[1] = in_valid & in_ready;
      for (int k = 2; k <= DEPTH; k++) begin
        if (adv[k]) v_d[k] = v_q[k-1];
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      occ_d = occ_d + OW'(v_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      occ_q  <= '0;
      mism_q <= 1'b0;
      d1_q   <= '0;
      d2_q   <= '0;
      for (int k = 1; k <= NP; k++) begin
        p1_q[k] <= '0;
        q1_q[k] <= '0;
        p2_q[k] <= '0;
        q2_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      if (fire_out && (d1_q != d2_q)) mism_q <= 1'b1;
      if (in_valid && in_ready) begin
        p1_q[1] <= a + b;
        q1_q[1] <= c;
        p2_q[1] <= a + c;
        q2_q[1] <= b;
      end
      // Flushed loads carry no valid entry, so payload stays untouched.
      for (int k = 2; k <= NP; k++) begin
        if (!flush && adv[k] && v_q[k-1]) begin
          p1_q[k] <= p1_q[k-1];
          q1_q[k] <= q1_q[k-1];
          p2_q[k] <= p2_q[k-1];
          q2_q[k] <= q2_q[k-1];
        end
      end
      if (!flush && adv[DEPTH] && v_q[NP]) begin
        d1_q <= p1_q[NP] + q1_q[NP];
        d2_q <= p2_q[NP] + q2_q[NP];
      end
    end
  end

  assign out_valid = v_q[DEPTH];
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign occupancy = occ_q;
  assign mismatch  = mism_q;

endmodule
`default_nettype wire

// File: tb/tb_stall_pipe_n.sv
`default_nettype none
// Directed bench for stall_pipe_n: one DEPTH=2 and one DEPTH=4 instance.
module tb_stall_pipe_n;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic         st, fl, iv, ordy, ir, ov, mm;
  logic [W-1:0] a, b, c, d1, d2;
  logic [2:0]   occ;

  logic         xiv, xordy, xir, xov, xmm;
  logic [W-1:0] xa, xb, xc, xd1, xd2;
  logic [1:0]   xocc;

  stall_pipe_n #(.W(W), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .stall(st), .flush(fl),
    .in_valid(iv), .in_ready(ir), .a(a), .b(b), .c(c),
    .out_valid(ov), .out_ready(ordy), .d1(d1), .d2(d2),
    .occupancy(occ), .mismatch(mm)
  );

  stall_pipe_n #(.W(W), .DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .flush(1'b0),
    .in_valid(xiv), .in_ready(xir), .a(xa), .b(xb), .c(xc),
    .out_valid(xov), .out_ready(xordy), .d1(xd1), .d2(xd2),
    .occupancy(xocc), .mismatch(xmm)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL reset_ov got=%0b exp=0", ov); end
    n_cmp++; if (occ !== 3'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occ); end
    n_cmp++; if (d1 !== 16'd0 || d2 !== 16'd0) begin n_err++; $display("FAIL reset_d got=%h/%h exp=0/0", d1, d2); end
    n_cmp++; if (mm !== 1'b0) begin n_err++; $display("FAIL reset_mm got=%0b exp=0", mm); end
    n_cmp++; if (xov !== 1'b0 || xocc !== 2'd0) begin n_err++; $display("FAIL reset_d2inst got=%0b/%0d exp=0/0", xov, xocc); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (ir !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", ir); end
  endtask

  task automatic test_basic;
    xordy = 1'b1;
    xiv = 1'b1; xa = 16'd1; xb = 16'd2; xc = 16'd3; #1;
    n_cmp++; if (xir !== 1'b1 || xov !== 1'b0) begin n_err++; $display("FAIL basic_c0 got ir=%0b ov=%0b exp ir=1 ov=0", xir, xov); end
    step();
    xa = 16'hFFFF; xb = 16'd1; xc = 16'd1; #1;
    n_cmp++; if (xir !== 1'b1 || xov !== 1'b0) begin n_err++; $display("FAIL basic_c1 got ir=%0b ov=%0b exp ir=1 ov=0", xir, xov); end
    step();
    xiv = 1'b0; #1;
    n_cmp++; if (xov !== 1'b1 || xd1 !== 16'd6 || xd2 !== 16'd6) begin n_err++; $display("FAIL basic_r1 got ov=%0b d=%h/%h exp 1 6/6", xov, xd1, xd2); end
    step();
    n_cmp++; if (xov !== 1'b1 || xd1 !== 16'd1 || xd2 !== 16'd1) begin n_err++; $display("FAIL basic_wrap got ov=%0b d=%h/%h exp 1 1/1", xov, xd1, xd2); end
    step();
    n_cmp++; if (xov !== 1'b0 || xd1 !== 16'd1) begin n_err++; $display("FAIL basic_idle got ov=%0b d1=%h exp 0 1", xov, xd1); end
    n_cmp++; if (xmm !== 1'b0) begin n_err++; $display("FAIL basic_mm got=%0b exp=0", xmm); end
  endtask

  task automatic test_backpressure;
    logic exp_ir;
    ordy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      iv = 1'b1; a = 16'(i); b = 16'(i); c = 16'd100; #1;
      exp_ir = (i <= 4) ? 1'b1 : 1'b0;
      n_cmp++; if (ir !== exp_ir) begin n_err++; $display("FAIL bp_ready[%0d] got=%0b exp=%0b", i, ir, exp_ir); end
      if (i <= 4) step();
    end
    n_cmp++; if (occ !== 3'd4 || ov !== 1'b1 || d1 !== 16'd102) begin n_err++; $display("FAIL bp_full got occ=%0d ov=%0b d1=%0d exp 4 1 102", occ, ov, d1); end
    ordy = 1'b1; #1;
    n_cmp++; if (ir !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%0b exp=1", ir); end
    step();
    iv = 1'b0;
    n_cmp++; if (occ !== 3'd4) begin n_err++; $display("FAIL bp_occ_swap got=%0d exp=4", occ); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ov !== 1'b1 || d1 !== 16'(104 + 2*k) || d2 !== 16'(104 + 2*k)) begin
        n_err++; $display("FAIL bp_drain[%0d] got ov=%0b d=%0d/%0d exp 1 %0d", k, ov, d1, d2, 104 + 2*k);
      end
      step();
    end
    n_cmp++; if (ov !== 1'b0 || occ !== 3'd0) begin n_err++; $display("FAIL bp_empty got ov=%0b occ=%0d exp 0 0", ov, occ); end
  endtask

  task automatic test_stall;
    int j = 1;
    int n = 1;
    logic acc;
    ordy = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      st = (cyc >= 5 && cyc <= 7);
      iv = (j <= 8); a = 16'(j); b = 16'(j); c = 16'(j); #1;
      if (st) begin
        n_cmp++;
        if (ir !== 1'b0 || ov !== 1'b1 || d1 !== 16'd6 || d2 !== 16'd6 || occ !== 3'd4) begin
          n_err++; $display("FAIL stall_frozen[%0d] got ir=%0b ov=%0b d=%0d/%0d occ=%0d exp 0 1 6/6 4", cyc, ir, ov, d1, d2, occ);
        end
      end
      if (ov && ordy && !st) begin
        n_cmp++;
        if (d1 !== 16'(3*n) || d2 !== 16'(3*n)) begin
          n_err++; $display("FAIL stall_seq[%0d] got=%0d/%0d exp=%0d", n, d1, d2, 3*n);
        end
        n++;
      end
      acc = iv && ir;
      step();
      if (acc) j++;
    end
    st = 1'b0; iv = 1'b0;
    n_cmp++; if (n != 9 || ov !== 1'b0) begin n_err++; $display("FAIL stall_count got n=%0d ov=%0b exp 9 0", n - 1 + 1, ov); end
    n_cmp++; if (mm !== 1'b0) begin n_err++; $display("FAIL stall_mm got=%0b exp=0", mm); end
  endtask

  task automatic test_bubbles;
    ordy = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      iv = (cyc % 2 == 0); a = 16'(20 + cyc/2); b = 16'd1; c = 16'd1;
      step();
    end
    iv = 1'b0; #1;
    n_cmp++; if (occ !== 3'd3 || ir !== 1'b1) begin n_err++; $display("FAIL bub_occ got occ=%0d ir=%0b exp 3 1", occ, ir); end
    ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (ov !== 1'b1 || d1 !== 16'(22 + k)) begin n_err++; $display("FAIL bub_out[%0d] got ov=%0b d1=%0d exp 1 %0d", k, ov, d1, 22 + k); end
      step();
    end
    n_cmp++; if (ov !== 1'b0 || occ !== 3'd0) begin n_err++; $display("FAIL bub_empty got ov=%0b occ=%0d exp 0 0", ov, occ); end
  endtask

  task automatic test_flush;
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; a = 16'(40 + k); b = 16'd0; c = 16'd0;
      step();
    end
    iv = 1'b0;
    step();
    n_cmp++; if (occ !== 3'd3 || ov !== 1'b1 || d1 !== 16'd40) begin n_err++; $display("FAIL fl_pre got occ=%0d ov=%0b d1=%0d exp 3 1 40", occ, ov, d1); end
    fl = 1'b1; ordy = 1'b1; iv = 1'b1; a = 16'd99; #1;
    n_cmp++; if (ir !== 1'b0) begin n_err++; $display("FAIL fl_ready got=%0b exp=0", ir); end
    step();
    fl = 1'b0; iv = 1'b0; #1;
    n_cmp++; if (occ !== 3'd0 || ov !== 1'b0 || d1 !== 16'd40 || ir !== 1'b1) begin
      n_err++; $display("FAIL fl_post got occ=%0d ov=%0b d1=%0d ir=%0b exp 0 0 40 1", occ, ov, d1, ir);
    end
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (ov !== 1'b0 || occ !== 3'd0) begin n_err++; $display("FAIL fl_noinput got ov=%0b occ=%0d exp 0 0", ov, occ); end
  endtask

  task automatic test_async_reset;
    ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv = 1'b1; a = 16'd7; b = 16'd8; c = 16'd9;
      step();
    end
    iv = 1'b0;
    n_cmp++; if (occ !== 3'd4 || ov !== 1'b1 || d1 !== 16'd24) begin n_err++; $display("FAIL ar_full got occ=%0d ov=%0b d1=%0d exp 4 1 24", occ, ov, d1); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ov !== 1'b0 || occ !== 3'd0 || d1 !== 16'd0 || d2 !== 16'd0 || mm !== 1'b0) begin
      n_err++; $display("FAIL ar_immediate got ov=%0b occ=%0d d=%0d/%0d mm=%0b exp all 0", ov, occ, d1, d2, mm);
    end
    @(negedge clk);
    rst_n = 1'b1;
    iv = 1'b1; a = 16'd1; b = 16'd1; c = 16'd1; ordy = 1'b1; #1;
    n_cmp++; if (ir !== 1'b1) begin n_err++; $display("FAIL ar_ready got=%0b exp=1", ir); end
    step();
    iv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL ar_lat[%0d] got ov=%0b exp=0", k, ov); end
      step();
    end
    n_cmp++; if (ov !== 1'b1 || d1 !== 16'd3 || d2 !== 16'd3) begin n_err++; $display("FAIL ar_first got ov=%0b d=%0d/%0d exp 1 3/3", ov, d1, d2); end
    step();
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL ar_drained got ov=%0b exp=0", ov); end
  endtask

  initial begin
    st = 1'b0; fl = 1'b0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; c = '0;
    xiv = 1'b0; xordy = 1'b0; xa = '0; xb = '0; xc = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_bubbles();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
